// File: rtl/sap1_controller_sequencer_if.sv
// SAP-1 controller/sequencer bus interface.
// Carries the opcode nibble from the instruction register into the controller
// and the control word, ring state and halt indication back out.
//   opcode  : IR upper nibble, valid T4..T6 (driven by master)
//   con     : 12-bit control word {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
//   t_state : one-hot ring state, bit0 = T1
//   nHlt    : low while halted
interface sap1_controller_sequencer_if;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        nHlt;

    // Master: the datapath side (IR supplies opcode, blocks consume con).
    modport master (
        output opcode,
        input  con,
        input  t_state,
        input  nHlt
    );

    // Slave: the controller/sequencer itself.
    modport slave (
        input  opcode,
        output con,
        output t_state,
        output nHlt
    );
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: six-state one-hot ring counter plus
// instruction decoder producing the 12-bit datapath control word.
//
// Ports:
//   clk  : system clock, rising edge
//   clr  : synchronous active-high reset
//   bus  : sap1_controller_sequencer_if.slave (opcode in; con, t_state, nHlt out)
//
// Optional build macro: SAP_VAR_CYCLE_EN
//   Defined   : execute states that would only emit NOP are skipped
//               (LDA ends after T5, OUT and undefined opcodes after T4).
//   Undefined : every instruction takes the fixed six states.
//
// con is combinational from ring state, opcode, halt flag and clr so the
// datapath acts on it at the very next rising edge.
module sap1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic                           clk,
    input  logic                           clr,
    sap1_controller_sequencer_if.slave     bus
);

    // Control words, bit order {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}.
    localparam logic [11:0] CW_NOP     = 12'h3E3;
    localparam logic [11:0] CW_FETCH1  = 12'h5E3;  // Ep, nLm
    localparam logic [11:0] CW_FETCH2  = 12'hBE3;  // Cp
    localparam logic [11:0] CW_FETCH3  = 12'h263;  // nCE, nLi
    localparam logic [11:0] CW_IR2MAR  = 12'h1A3;  // nLm, nEi
    localparam logic [11:0] CW_RAM2A   = 12'h2C3;  // nCE, nLa
    localparam logic [11:0] CW_RAM2B   = 12'h2E1;  // nCE, nLb
    localparam logic [11:0] CW_ADD2A   = 12'h3C7;  // nLa, Eu
    localparam logic [11:0] CW_SUB2A   = 12'h3CF;  // nLa, Eu, Su
    localparam logic [11:0] CW_A2OUT   = 12'h3F2;  // Ea, nLo

    // One-hot encoding doubles as the t_state output.
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    state_t      state_q, state_d;
    logic        halt_q, halt_d;
    logic [11:0] con_c;
    logic        op_known;

    assign op_known = (bus.opcode == OP_LDA) || (bus.opcode == OP_ADD) ||
                      (bus.opcode == OP_SUB) || (bus.opcode == OP_OUT) ||
                      (bus.opcode == OP_HLT);

    // Next ring state and halt flag.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (!halt_q) begin
            case (state_q)
                T1: state_d = T2;
                T2: state_d = T3;
                T3: state_d = T4;
                T4: begin
                    if (bus.opcode == OP_HLT) begin
                        // Freeze in T4; only clr leaves the halted state.
                        halt_d = 1'b1;
                    end else begin
                        state_d = T5;
`ifdef SAP_VAR_CYCLE_EN
                        if (bus.opcode == OP_OUT || !op_known)
                            state_d = T1;
`endif
                    end
                end
                T5: begin
                    state_d = T6;
`ifdef SAP_VAR_CYCLE_EN
                    if (bus.opcode == OP_LDA)
                        state_d = T1;
`endif
                end
                T6:      state_d = T1;
                default: state_d = T1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= T1;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Control word decode.
    always_comb begin
        con_c = CW_NOP;
        if (!clr && !halt_q) begin
            case (state_q)
                T1: con_c = CW_FETCH1;
                T2: con_c = CW_FETCH2;
                T3: con_c = CW_FETCH3;
                T4: begin
                    if (bus.opcode == OP_LDA || bus.opcode == OP_ADD ||
                        bus.opcode == OP_SUB)
                        con_c = CW_IR2MAR;
                    else if (bus.opcode == OP_OUT)
                        con_c = CW_A2OUT;
                end
                T5: begin
                    if (bus.opcode == OP_LDA)
                        con_c = CW_RAM2A;
                    else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB)
                        con_c = CW_RAM2B;
                end
                T6: begin
                    if (bus.opcode == OP_ADD)
                        con_c = CW_ADD2A;
                    else if (bus.opcode == OP_SUB)
                        con_c = CW_SUB2A;
                end
                default: con_c = CW_NOP;
            endcase
        end
    end

    assign bus.con     = con_c;
    assign bus.t_state = state_q;
    assign bus.nHlt    = ~halt_q;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
module tb_sap1_controller_sequencer;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;

    sap1_controller_sequencer_if bus ();

    sap1_controller_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] c_exp,
                       input logic [5:0] t_exp, input logic h_exp);
        n_tests++;
        assert (bus.con === c_exp && bus.t_state === t_exp && bus.nHlt === h_exp)
        else begin
            n_fail++;
            $error("FAIL %s: got con=%h t=%b nHlt=%b, expected con=%h t=%b nHlt=%b",
                   tag, bus.con, bus.t_state, bus.nHlt, c_exp, t_exp, h_exp);
        end
    endtask

    // Runs one instruction starting in T1. early_op is driven during T1..T3 to
    // show fetch ignores the opcode; op is applied before T4. last is the
    // final state index (3=T4, 4=T5, 5=T6). Ends back in T1.
    task automatic instr(input string tag, input logic [3:0] early_op,
                         input logic [3:0] op, input logic [11:0] e4,
                         input logic [11:0] e5, input logic [11:0] e6,
                         input int last);
        bus.opcode = early_op;
        chk({tag, "_T1"}, 12'h5E3, 6'b000001, 1'b1);
        step();
        chk({tag, "_T2"}, 12'hBE3, 6'b000010, 1'b1);
        step();
        chk({tag, "_T3"}, 12'h263, 6'b000100, 1'b1);
        bus.opcode = op;
        step();
        chk({tag, "_T4"}, e4, 6'b001000, 1'b1);
        if (last >= 4) begin
            step();
            chk({tag, "_T5"}, e5, 6'b010000, 1'b1);
        end
        if (last >= 5) begin
            step();
            chk({tag, "_T6"}, e6, 6'b100000, 1'b1);
        end
        step();
        chk({tag, "_wrap"}, 12'h5E3, 6'b000001, 1'b1);
    endtask

    initial begin
        int lda_last;
        int out_last;
        n_tests    = 0;
        n_fail     = 0;
        clr        = 1'b1;
        bus.opcode = 4'h0;
`ifdef SAP_VAR_CYCLE_EN
        lda_last = 4;
        out_last = 3;
`else
        lda_last = 5;
        out_last = 5;
`endif

        // Reset: two edges with clr high, con forced inactive.
        #1;
        chk("clr_async_view", 12'h3E3, bus.t_state, bus.nHlt === 1'b1 ? 1'b1 : 1'b0);
        step();
        chk("clr_edge1", 12'h3E3, 6'b000001, 1'b1);
        step();
        chk("clr_edge2", 12'h3E3, 6'b000001, 1'b1);
        clr = 1'b0;
        #1;
        chk("reset_T1", 12'h5E3, 6'b000001, 1'b1);

        // Arithmetic and load/output instructions.
        instr("ADD", 4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7, 5);
        instr("SUB", 4'h2, 4'h2, 12'h1A3, 12'h2E1, 12'h3CF, 5);
        instr("LDA", 4'h0, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3, lda_last);
        instr("OUT", 4'hE, 4'hE, 12'h3F2, 12'h3E3, 12'h3E3, out_last);
        instr("UND", 4'h7, 4'h7, 12'h3E3, 12'h3E3, 12'h3E3, out_last);
        // HLT present during fetch must not halt; ADD decoded at T4.
        instr("ADDlate", 4'hF, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7, 5);

        // clr during ADD T5 abandons the instruction.
        bus.opcode = 4'h1;
        step(); step(); step(); step();
        chk("abort_T5", 12'h2E1, 6'b010000, 1'b1);
        clr = 1'b1;
        #1;
        chk("abort_clr_con", 12'h3E3, 6'b010000, 1'b1);
        step();
        chk("abort_next", 12'h3E3, 6'b000001, 1'b1);
        clr = 1'b0;
        #1;
        chk("abort_T1", 12'h5E3, 6'b000001, 1'b1);

        // HLT: freeze in T4 with nHlt low until clr.
        bus.opcode = 4'hF;
        step(); step(); step();
        chk("hlt_T4", 12'h3E3, 6'b001000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("halted_%0d", i), 12'h3E3, 6'b001000, 1'b0);
        end
        clr = 1'b1;
        step();
        chk("hlt_clr", 12'h3E3, 6'b000001, 1'b1);
        clr = 1'b0;
        bus.opcode = 4'h1;
        #1;
        chk("hlt_restart", 12'h5E3, 6'b000001, 1'b1);
        instr("ADDpost", 4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
